// File: rtl/frame_capture_seq.sv
// Camera pixel capture sequencer: packs three 12-bit pixels per 36-bit FIFO word
// for one frame per synchronized start request, then waits for the reader to drain.
module frame_capture_seq #(
  parameter logic [19:0] WORDS_PER_FRAME = 20'd102400,
  parameter int          SYNC_STAGES     = 2
) (
  input  logic        D5M_PIXLCLK,
  input  logic        RST_N,
  input  logic        iFVAL,
  input  logic [11:0] iDATA,
  input  logic        iDATA_VAL,
  input  logic        start_req,
  input  logic        drain_done,
  input  logic        wrfull,
  output logic [35:0] wr_word,
  output logic        wrreq,
  output logic        busy,
  output logic        frame_done,
  output logic [19:0] word_count,
  output logic        overflow,
  output logic        short_frame
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DRAIN_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] startSync_q, drainSync_q;
  logic                   startPrev_q, fvalPrev_q;
  logic [1:0]             lane_q;
  logic [11:0]            lane0_q, lane1_q;
  logic [35:0]            word_q;
  logic                   wrPend_q;
  logic [19:0]            count_q;
  logic                   overflow_q, short_q, frameDone_q;

  logic startPulse, drainSeen, startGo, sofSeen;
  logic writeFire, finalWrite, captureEnd, pixelTake;

  assign startPulse = startSync_q[SYNC_STAGES-1] & ~startPrev_q;
  assign drainSeen  = drainSync_q[SYNC_STAGES-1];
  assign startGo    = (state_q == IDLE) && startPulse;
  assign sofSeen    = (state_q == WAIT_SOF) && iFVAL && !fvalPrev_q;
  assign writeFire  = wrPend_q & ~wrfull;
  // The last word wins over a simultaneous FVAL fall, so that frame counts as complete.
  assign finalWrite = (state_q == CAPTURE) && writeFire && (count_q == WORDS_PER_FRAME - 20'd1);
  assign captureEnd = (state_q == CAPTURE) && (finalWrite || !iFVAL);
  assign pixelTake  = (state_q == CAPTURE) && !captureEnd && iDATA_VAL;

  always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (startPulse) state_d = WAIT_SOF;
      WAIT_SOF:   if (sofSeen)    state_d = CAPTURE;
      CAPTURE:    if (captureEnd) state_d = DRAIN_WAIT;
      DRAIN_WAIT: if (drainSeen)  state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    wrreq       = writeFire;
    wr_word     = word_q;
    frame_done  = frameDone_q;
    word_count  = count_q;
    overflow    = overflow_q;
    short_frame = short_q;
  end

  always_ff @(posedge D5M_PIXLCLK or negedge RST_N) begin
    if (!RST_N) begin
      startSync_q <= '0;
      drainSync_q <= '0;
      startPrev_q <= 1'b0;
      fvalPrev_q  <= 1'b0;
      lane_q      <= 2'd0;
      lane0_q     <= 12'd0;
      lane1_q     <= 12'd0;
      word_q      <= 36'd0;
      wrPend_q    <= 1'b0;
      count_q     <= 20'd0;
      overflow_q  <= 1'b0;
      short_q     <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        startSync_q[i] <= startSync_q[i-1];
        drainSync_q[i] <= drainSync_q[i-1];
      end
      startSync_q[0] <= start_req;
      drainSync_q[0] <= drain_done;
      startPrev_q    <= startSync_q[SYNC_STAGES-1];
      fvalPrev_q     <= iFVAL;
      wrPend_q       <= pixelTake && (lane_q == 2'd2);
      frameDone_q    <= captureEnd;

      if (pixelTake) begin
        case (lane_q)
          2'd0:    begin lane0_q <= iDATA; lane_q <= 2'd1; end
          2'd1:    begin lane1_q <= iDATA; lane_q <= 2'd2; end
          default: begin word_q <= {iDATA, lane1_q, lane0_q}; lane_q <= 2'd0; end
        endcase
      end
      // Partial words never survive a capture boundary.
      if (startGo || captureEnd) lane_q <= 2'd0;

      if (startGo) begin
        count_q    <= 20'd0;
        overflow_q <= 1'b0;
        short_q    <= 1'b0;
      end else begin
        if (writeFire && (count_q != WORDS_PER_FRAME)) count_q <= count_q + 20'd1;
        if (wrPend_q && wrfull)                         overflow_q <= 1'b1;
        if (captureEnd && !finalWrite)                  short_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_seq.sv
// Directed bench for frame_capture_seq with a 5-word frame; a negedge monitor logs
// every FIFO write and frame_done pulse for the scenario checks.
module tb_frame_capture_seq;

  logic        D5M_PIXLCLK = 1'b0;
  logic        RST_N, iFVAL, iDATA_VAL, start_req, drain_done, wrfull;
  logic [11:0] iDATA;
  logic [35:0] wr_word;
  logic        wrreq, busy, frame_done, overflow, short_frame;
  logic [19:0] word_count;

  int          errCount = 0;
  int          checkCount = 0;
  int          wrTotal = 0;
  int          fdTotal = 0;
  int          lateCnt = 0;
  logic        prevLane2 = 1'b0;
  logic [35:0] wordLog[$];

  frame_capture_seq #(.WORDS_PER_FRAME(20'd5), .SYNC_STAGES(2)) dut (
    .D5M_PIXLCLK(D5M_PIXLCLK), .RST_N(RST_N), .iFVAL(iFVAL), .iDATA(iDATA),
    .iDATA_VAL(iDATA_VAL), .start_req(start_req), .drain_done(drain_done),
    .wrfull(wrfull), .wr_word(wr_word), .wrreq(wrreq), .busy(busy),
    .frame_done(frame_done), .word_count(word_count), .overflow(overflow),
    .short_frame(short_frame)
  );

  always #5 D5M_PIXLCLK = ~D5M_PIXLCLK;

  // Write latency is judged against whether the previous cycle carried a lane-2 pixel.
  always @(negedge D5M_PIXLCLK) begin
    if (wrreq === 1'b1) begin
      wrTotal++;
      wordLog.push_back(wr_word);
      if (!prevLane2) lateCnt++;
    end
    if (frame_done === 1'b1) fdTotal++;
    prevLane2 = iDATA_VAL && iFVAL && (iDATA % 3 == 0);
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] expWord(input int k);
    return {12'(3 * k), 12'(3 * k - 1), 12'(3 * k - 2)};
  endfunction

  task automatic stepClk();
    @(posedge D5M_PIXLCLK);
    #1;
  endtask

  task automatic checkWord(input string tag, input int idx, input int k);
    if (idx < wordLog.size()) checkOutput(tag, {28'd0, wordLog[idx]}, {28'd0, expWord(k)});
    else checkOutput({tag, " logged"}, wordLog.size(), idx + 1);
  endtask

  task automatic doStart();
    start_req = 1'b1;
    repeat (4) stepClk();
    start_req = 1'b0;
  endtask

  task automatic fvalRise();
    iFVAL = 1'b1;
    iDATA_VAL = 1'b1;
    iDATA = 12'hABD;
    stepClk();
    iDATA_VAL = 1'b0;
  endtask

  // Feeds pixels 1..nPix (one valid every gap+1 cycles); dropWord holds wrfull in that word's write cycle.
  task automatic applyStimulus(input int nPix, input int gap, input int dropWord,
                               input bit tailFall, input bit toggleStart);
    int p = 0;
    int c = 0;
    int pend = 0;
    while (p < nPix) begin
      wrfull = (pend != 0) && (pend == dropWord);
      pend = 0;
      if (toggleStart) start_req = ((c % 6) < 3);
      if (c % (gap + 1) == 0) begin
        p++;
        iDATA = 12'(p);
        iDATA_VAL = 1'b1;
        if (p % 3 == 0) pend = p / 3;
      end else begin
        iDATA_VAL = 1'b0;
      end
      c++;
      stepClk();
    end
    iDATA_VAL = 1'b0;
    wrfull = (pend != 0) && (pend == dropWord);
    if (tailFall) iFVAL = 1'b0;
    if (toggleStart) start_req = 1'b0;
    stepClk();
    wrfull = 1'b0;
  endtask

  task automatic finishDrain(input string tag);
    int n = 0;
    drain_done = 1'b1;
    while (busy && n < 10) begin
      stepClk();
      n++;
    end
    checkOutput({tag, " drain to idle"}, busy, 0);
    drain_done = 1'b0;
    repeat (4) stepClk();
  endtask

  int wBase, fBase;

  initial begin
    RST_N = 1'b0; iFVAL = 1'b0; iDATA = 12'd0; iDATA_VAL = 1'b0;
    start_req = 1'b0; drain_done = 1'b0; wrfull = 1'b0;
    repeat (3) stepClk();
    checkOutput("reset busy", busy, 0);
    checkOutput("reset wrreq", wrreq, 0);
    checkOutput("reset word_count", word_count, 0);
    checkOutput("reset flags", {frame_done, overflow, short_frame}, 0);
    checkOutput("reset wr_word", wr_word, 0);

    // Start held across reset release must take exactly three edges to land.
    start_req = 1'b1;
    RST_N = 1'b1;
    repeat (2) stepClk();
    checkOutput("start not before 3 edges", busy, 0);
    stepClk();
    checkOutput("start after 3 edges", busy, 1);
    start_req = 1'b0;
    stepClk();

    $display("[TB] full frame");
    wBase = wordLog.size(); fBase = fdTotal;
    fvalRise();
    applyStimulus(15, 0, 0, 1'b0, 1'b0);
    stepClk();
    checkOutput("s1 wrreq pulses", wrTotal - wBase, 5);
    if (wordLog.size() > wBase) checkOutput("s1 first word", {28'd0, wordLog[wBase]}, 64'h3002001);
    for (int i = 1; i < 5; i++) checkWord($sformatf("s1 word%0d", i), wBase + i, i + 1);
    checkOutput("s1 word_count", word_count, 5);
    checkOutput("s1 frame_done", fdTotal - fBase, 1);
    checkOutput("s1 busy in drain", busy, 1);
    checkOutput("s1 flags", {overflow, short_frame}, 0);
    iFVAL = 1'b0;
    repeat (3) stepClk();
    checkOutput("s1 no extra frame_done", fdTotal - fBase, 1);
    finishDrain("s1");

    $display("[TB] dropped third word");
    doStart();
    wBase = wordLog.size(); fBase = fdTotal;
    fvalRise();
    applyStimulus(15, 0, 3, 1'b0, 1'b0);
    iFVAL = 1'b0;
    repeat (2) stepClk();
    checkOutput("s2 wrreq pulses", wrTotal - wBase, 4);
    checkWord("s2 word2", wBase + 2, 4);
    checkWord("s2 word3", wBase + 3, 5);
    checkOutput("s2 word_count", word_count, 4);
    checkOutput("s2 overflow", overflow, 1);
    checkOutput("s2 short_frame", short_frame, 1);
    checkOutput("s2 frame_done", fdTotal - fBase, 1);
    finishDrain("s2");
    checkOutput("s2 sticky in idle", {overflow, short_frame}, 2'b11);

    $display("[TB] short frame");
    doStart();
    checkOutput("s3 flags cleared on start", {overflow, short_frame}, 0);
    wBase = wordLog.size(); fBase = fdTotal;
    fvalRise();
    applyStimulus(7, 0, 0, 1'b0, 1'b0);
    iFVAL = 1'b0;
    repeat (2) stepClk();
    checkOutput("s3 wrreq pulses", wrTotal - wBase, 2);
    checkOutput("s3 word_count", word_count, 2);
    checkOutput("s3 short_frame", short_frame, 1);
    checkOutput("s3 frame_done", fdTotal - fBase, 1);
    finishDrain("s3");

    $display("[TB] gapped pixels with start toggling");
    doStart();
    wBase = wordLog.size(); fBase = fdTotal;
    fvalRise();
    applyStimulus(15, 2, 0, 1'b0, 1'b1);
    stepClk();
    checkOutput("s4 wrreq pulses", wrTotal - wBase, 5);
    for (int i = 0; i < 5; i++) checkWord($sformatf("s4 word%0d", i), wBase + i, i + 1);
    checkOutput("s4 wrreq latency", lateCnt, 0);
    checkOutput("s4 word_count", word_count, 5);
    repeat (3) begin
      start_req = 1'b1;
      repeat (2) stepClk();
      start_req = 1'b0;
      repeat (2) stepClk();
    end
    iFVAL = 1'b0;
    repeat (5) stepClk();
    checkOutput("s4 drain holds under start", busy, 1);
    checkOutput("s4 frame_done once", fdTotal - fBase, 1);
    finishDrain("s4");
    repeat (6) stepClk();
    checkOutput("s4 start not queued", busy, 0);

    $display("[TB] reset mid-capture and restart");
    doStart();
    fvalRise();
    applyStimulus(7, 0, 0, 1'b0, 1'b0);
    checkOutput("s5 pre-reset count", word_count, 2);
    RST_N = 1'b0;
    #3;
    checkOutput("s5 reset busy/wrreq/done", {busy, wrreq, frame_done}, 0);
    checkOutput("s5 reset word_count", word_count, 0);
    checkOutput("s5 reset wr_word", wr_word, 0);
    iFVAL = 1'b0;
    repeat (2) stepClk();
    RST_N = 1'b1;
    doStart();
    checkOutput("s5 restart busy", busy, 1);
    checkOutput("s5 restart word_count", word_count, 0);
    wBase = wordLog.size(); fBase = fdTotal;
    fvalRise();
    applyStimulus(15, 0, 0, 1'b1, 1'b0);
    repeat (2) stepClk();
    checkOutput("s5 wrreq pulses", wrTotal - wBase, 5);
    checkWord("s5 first word", wBase, 1);
    checkOutput("s5 word_count", word_count, 5);
    checkOutput("s5 last-word fall not short", short_frame, 0);
    checkOutput("s5 frame_done", fdTotal - fBase, 1);
    finishDrain("s5");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/frame_capture_seq.md
FRAME_CAPTURE_SEQ -- requirements
Module: frame_capture_seq

Interface
REQ-001 Parameter WORDS_PER_FRAME, default 20'd102400; 36-bit words per captured frame (640x480 / 3).
REQ-002 Parameter SYNC_STAGES, default 2; flop stages on each CLK-domain input.
REQ-003 D5M_PIXLCLK  in  1  pixel clock; all state updates on its rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 iFVAL  in  1  camera frame-valid.
REQ-006 iDATA  in  12  pixel data.
REQ-007 iDATA_VAL  in  1  pixel qualifier.
REQ-008 start_req  in  1  capture request level from CLK domain; asynchronous to D5M_PIXLCLK.
REQ-009 drain_done  in  1  read side finished emptying FIFO; CLK domain level.
REQ-010 wrfull  in  1  FIFO write-side full.
REQ-011 wr_word  out  36  packed word to FIFO.
REQ-012 wrreq  out  1  FIFO write strobe, one cycle per word.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 frame_done  out  1  one-cycle pulse on capture completion.
REQ-015 word_count  out  20  words written in current capture.
REQ-016 overflow  out  1  sticky; a word was dropped because wrfull was high.
REQ-017 short_frame  out  1  sticky; iFVAL fell before WORDS_PER_FRAME words.

Function
REQ-018 start_req and drain_done SHALL each pass through a SYNC_STAGES flop synchronizer before use; start is the rising edge of synchronized start_req.
REQ-019 States: IDLE, WAIT_SOF, CAPTURE, DRAIN_WAIT.
REQ-020 IDLE -> WAIT_SOF on start; on that transition clear word_count, overflow, short_frame and the pixel lane counter.
REQ-021 WAIT_SOF -> CAPTURE on iFVAL=1 with previous-cycle iFVAL=0; pixels on the detection cycle are discarded.
REQ-022 CAPTURE: each cycle with iDATA_VAL=1 stores iDATA in lane 0,1,2 in order; lane counter wraps 2 -> 0.
REQ-023 Packing: wr_word = {lane2, lane1, lane0}; lane0 in bits [11:0].
REQ-024 wrreq SHALL pulse exactly one cycle, the cycle after the lane-2 pixel is sampled, with wr_word stable that cycle.
REQ-025 If wrfull=1 in the cycle the word would be written: no wrreq, word dropped, overflow set, word_count unchanged.
REQ-026 word_count increments by one per asserted wrreq; saturates at WORDS_PER_FRAME.
REQ-027 When word_count reaches WORDS_PER_FRAME: CAPTURE -> DRAIN_WAIT; frame_done pulses that same cycle; further pixels ignored.
REQ-028 iFVAL falling in CAPTURE before completion: -> DRAIN_WAIT, short_frame set, frame_done pulses, partial lanes discarded.
REQ-029 Final wrreq and iFVAL fall in the same cycle: counted as complete; short_frame stays 0.
REQ-030 DRAIN_WAIT -> IDLE when synchronized drain_done=1; start during DRAIN_WAIT or CAPTURE is ignored (not queued).
REQ-031 overflow and short_frame hold their values through IDLE until the next start.

Reset
REQ-032 RST_N low, at any time including mid-capture: state IDLE, lanes and synchronizers cleared, wr_word=0, wrreq=0, busy=0, frame_done=0, word_count=0, overflow=0, short_frame=0.
REQ-033 First start after reset deassertion is recognized only after SYNC_STAGES+1 D5M_PIXLCLK edges.

Verification (WORDS_PER_FRAME=5)
REQ-034 Start, FVAL rise, 15 valid pixels 0x001..0x00F -> 5 wrreq pulses, first word 36'h003_002_001, word_count=5, one frame_done, busy=1 until drain_done.
REQ-035 wrfull=1 during the 3rd word -> 4 wrreq pulses, overflow=1, word_count=4 at FVAL fall, short_frame=1.
REQ-036 FVAL falls after 7 pixels -> 2 wrreq pulses, short_frame=1, frame_done pulse, 7th pixel discarded.
REQ-037 iDATA_VAL gaps (valid every 3rd cycle) -> same 5 words as REQ-034; each wrreq one cycle after its lane-2 pixel.
REQ-038 RST_N low after 2 words, then release and restart -> all outputs 0 during reset; new capture starts with word_count=0 and pixel lanes empty.
REQ-039 start_req toggled during CAPTURE and DRAIN_WAIT -> no state change; new capture only after drain_done returns to IDLE.
